// File: rtl/minterm_scanner.sv
// Truth-table scanner for a 4-input combinational function: steps the select
// code through 0..15, samples the function output, and reports table/popcount/match.
module minterm_scanner #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [15:0] i_exp,
  input  logic        i_f,
  output logic [3:0]  o_w,
  output logic        o_busy,
  output logic        o_done,
  output logic [15:0] o_table,
  output logic [4:0]  o_count,
  output logic        o_match
);

  if (SETTLE < 1 || SETTLE > 7) begin : g_bad_settle
    $error("minterm_scanner: SETTLE must be in 1..7");
  end

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  localparam logic [2:0] SETTLE_LAST = 3'(SETTLE - 1);

  logic [1:0]  r_state;
  logic [3:0]  r_w;
  logic [2:0]  r_cnt;
  logic [15:0] r_table;
  logic [15:0] r_exp_q;
  logic [4:0]  r_count;
  logic        r_match;

  logic        w_sample;
  logic [15:0] w_table_next;

  assign w_sample = (r_cnt == SETTLE_LAST);

  // The final sample must be part of the match compare on the SCAN->FIN edge.
  always_comb begin
    // NOTE: default first so the indexed write below cannot infer a latch.
    w_table_next       = r_table;
    w_table_next[r_w]  = i_f;
  end

  // NOTE: non-blocking assignments keep every register update edge-aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_w     <= 4'd0;
      r_cnt   <= 3'd0;
      r_table <= 16'h0000;
      r_exp_q <= 16'h0000;
      r_count <= 5'd0;
      r_match <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_SCAN;
            r_w     <= 4'd0;
            r_cnt   <= 3'd0;
            r_table <= 16'h0000;
            r_count <= 5'd0;
            r_match <= 1'b0;
            r_exp_q <= i_exp;
          end
        end
        ST_SCAN: begin
          if (w_sample) begin
            r_table <= w_table_next;
            r_count <= r_count + {4'd0, i_f};
            r_cnt   <= 3'd0;
            if (r_w == 4'd15) begin
              r_state <= ST_FIN;
              r_w     <= 4'd0;
              r_match <= (w_table_next == r_exp_q);
            end else begin
              r_w <= r_w + 4'd1;
            end
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        ST_FIN:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_w     = r_w;
  assign o_busy  = (r_state == ST_SCAN);
  assign o_done  = (r_state == ST_FIN);
  assign o_table = r_table;
  assign o_count = r_count;
  assign o_match = r_match;

endmodule

// File: tb/tb_minterm_scanner.sv
// Bench for minterm_scanner: a modelled 4-input decoder feeds two instances
// (SETTLE=1 and SETTLE=3); expected scan results go through a scoreboard queue.
module tb_minterm_scanner;

  typedef struct packed {
    logic [15:0] tt;
    logic [4:0]  cnt;
    logic        m;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] exp_word;
  logic [15:0] fn_tt;
  logic        sel3;

  logic [3:0]  w1, w3;
  logic        busy1, busy3, done1, done3, match1, match3;
  logic [15:0] table1, table3;
  logic [4:0]  count1, count3;
  logic        f1, f3;

  logic [3:0]  w_obs;
  logic        busy_obs, done_obs, match_obs;
  logic [15:0] table_obs;
  logic [4:0]  count_obs;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  // Decoder stage: f is the function's truth-table bit selected by w.
  assign f1 = fn_tt[w1];
  assign f3 = fn_tt[w3];

  minterm_scanner #(.SETTLE(1)) u_s1 (
    .clk(clk), .rst(rst), .i_start(start), .i_exp(exp_word), .i_f(f1),
    .o_w(w1), .o_busy(busy1), .o_done(done1), .o_table(table1),
    .o_count(count1), .o_match(match1)
  );

  minterm_scanner #(.SETTLE(3)) u_s3 (
    .clk(clk), .rst(rst), .i_start(start), .i_exp(exp_word), .i_f(f3),
    .o_w(w3), .o_busy(busy3), .o_done(done3), .o_table(table3),
    .o_count(count3), .o_match(match3)
  );

  always_comb begin
    w_obs     = sel3 ? w3     : w1;
    busy_obs  = sel3 ? busy3  : busy1;
    done_obs  = sel3 ? done3  : done1;
    table_obs = sel3 ? table3 : table1;
    count_obs = sel3 ? count3 : count1;
    match_obs = sel3 ? match3 : match1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_expected(input logic [15:0] tt, input logic [15:0] ex);
    exp_t e;
    e.tt  = tt;
    e.cnt = 5'($countones(tt));
    e.m   = (tt == ex);
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    rst   = 1'b0;
  endtask

  // Caller is positioned at the negedge just after the accepting edge E0.
  task automatic watch_scan(input int s, input string name);
    int   t_done;
    int   busy_cnt;
    bit   w_bad;
    exp_t e;
    t_done   = -1;
    busy_cnt = 0;
    w_bad    = 1'b0;
    for (int t = 0; t <= 16 * s + 3; t++) begin
      if (t != 0) @(negedge clk);
      if (done_obs === 1'b1) begin
        t_done = t;
        break;
      end
      if (busy_obs === 1'b1) busy_cnt++;
      if (w_obs !== 4'(t / s)) w_bad = 1'b1;
    end
    checks++;
    if (t_done != 16 * s) begin
      errors++;
      $display("FAIL %s done_latency: got %0d cycles, expected %0d", name, t_done, 16 * s);
    end
    checks++;
    if (w_bad) begin
      errors++;
      $display("FAIL %s w_sequence: w did not step once every %0d cycles from 0", name, s);
    end
    checks++;
    if (busy_cnt != 16 * s) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d, expected %0d", name, busy_cnt, 16 * s);
    end
    checks++;
    if (busy_obs !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_with_done: got %b, expected 0", name, busy_obs);
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard: no expected entry queued", name);
    end else begin
      e = sb.pop_front();
      checks++;
      if (table_obs !== e.tt) begin
        errors++;
        $display("FAIL %s table: got %h, expected %h", name, table_obs, e.tt);
      end
      checks++;
      if (count_obs !== e.cnt) begin
        errors++;
        $display("FAIL %s count: got %0d, expected %0d", name, count_obs, e.cnt);
      end
      checks++;
      if (match_obs !== e.m) begin
        errors++;
        $display("FAIL %s match: got %b, expected %b", name, match_obs, e.m);
      end
    end
  endtask

  task automatic run_scan(input bit use3, input logic [15:0] tt, input logic [15:0] ex,
                          input string name);
    int s;
    s = use3 ? 3 : 1;
    do_reset();
    sel3     = use3;
    fn_tt    = tt;
    exp_word = ex;
    start    = 1'b1;
    push_expected(tt, ex);
    @(negedge clk);
    start = 1'b0;
    watch_scan(s, name);
    @(negedge clk);
    checks++;
    if (done_obs !== 1'b0 || busy_obs !== 1'b0 || w_obs !== 4'd0) begin
      errors++;
      $display("FAIL %s after_fin: got done=%b busy=%b w=%0d, expected 0 0 0",
               name, done_obs, busy_obs, w_obs);
    end
  endtask

  task automatic test_reset();
    sel3  = 1'b0;
    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (w_obs !== 4'd0 || busy_obs !== 1'b0 || done_obs !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got w=%0d busy=%b done=%b, expected 0 0 0", w_obs, busy_obs, done_obs);
    end
    checks++;
    if (table_obs !== 16'h0000 || count_obs !== 5'd0 || match_obs !== 1'b0) begin
      errors++;
      $display("FAIL reset_result: got table=%h count=%0d match=%b, expected 0000 0 0",
               table_obs, count_obs, match_obs);
    end
    rst = 1'b0;
  endtask

  task automatic test_function();
    run_scan(1'b0, 16'hA352, 16'hA352, "func_match");
  endtask

  task automatic test_mismatch();
    run_scan(1'b0, 16'hA352, 16'hA353, "func_mismatch");
  endtask

  task automatic test_constants();
    run_scan(1'b0, 16'hFFFF, 16'hFFFF, "const_ones");
    run_scan(1'b0, 16'h0000, 16'h0000, "const_zeros");
  endtask

  task automatic test_settle3();
    run_scan(1'b1, 16'hA352, 16'hA352, "settle3");
  endtask

  task automatic test_mid_reset();
    bit reached;
    do_reset();
    sel3     = 1'b0;
    fn_tt    = 16'hA352;
    exp_word = 16'hA352;
    start    = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (w_obs === 4'd7) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL midrst_reach_w7: got w=%0d, expected 7 within 20 cycles", w_obs);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (w_obs !== 4'd0 || busy_obs !== 1'b0 || done_obs !== 1'b0 ||
        table_obs !== 16'h0000 || count_obs !== 5'd0 || match_obs !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: got w=%0d busy=%b done=%b table=%h count=%0d match=%b, expected all 0",
               w_obs, busy_obs, done_obs, table_obs, count_obs, match_obs);
    end
    @(negedge clk);
    rst = 1'b0;
    run_scan(1'b0, 16'hA352, 16'hA352, "midrst_rescan");
  endtask

  task automatic test_back_to_back();
    do_reset();
    sel3     = 1'b0;
    fn_tt    = 16'hA352;
    exp_word = 16'hA352;
    start    = 1'b1;
    push_expected(16'hA352, 16'hA352);
    @(negedge clk);
    watch_scan(1, "b2b_first");
    @(negedge clk);
    checks++;
    if (busy_obs !== 1'b0 || done_obs !== 1'b0 || table_obs !== 16'hA352 ||
        count_obs !== 5'd7 || match_obs !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle_hold: got busy=%b done=%b table=%h count=%0d match=%b, expected 0 0 a352 7 1",
               busy_obs, done_obs, table_obs, count_obs, match_obs);
    end
    @(negedge clk);
    checks++;
    if (busy_obs !== 1'b1 || table_obs !== 16'h0000 || count_obs !== 5'd0 ||
        match_obs !== 1'b0 || w_obs !== 4'd0) begin
      errors++;
      $display("FAIL b2b_second_accept: got busy=%b table=%h count=%0d match=%b w=%0d, expected 1 0000 0 0 0",
               busy_obs, table_obs, count_obs, match_obs, w_obs);
    end
    start = 1'b0;
    push_expected(16'hA352, 16'hA352);
    watch_scan(1, "b2b_second");
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    exp_word = 16'h0000;
    fn_tt    = 16'h0000;
    sel3     = 1'b0;
    test_reset();
    test_function();
    test_mismatch();
    test_constants();
    test_settle3();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
